// File: rtl/fifo_sel_pkg.sv
// Shared definitions for the FIFO select arbiter family: selection code encoding,
// FSM state type and the {valid, index} code helper.
package fifo_sel_pkg;

  localparam logic [7:0] NON_FIFO_CHOOSE = 8'd0;
  localparam int         SEL_VALID_BIT   = 7;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } sel_state_e;

  function automatic logic [7:0] sel_code(input logic [6:0] idx);
    return 8'd128 + {1'b0, idx};
  endfunction

endpackage

// File: rtl/fifo_sel_rr_pick.sv
// Combinational wrap-around priority search: first set request bit strictly
// after last_idx, wrapping from PORT_NUM-1 back to 0.
module fifo_sel_rr_pick
  import fifo_sel_pkg::*;
#(
  parameter int PORT_NUM = 4,
  parameter int IDX_W    = 7
) (
  input  logic [PORT_NUM-1:0] req,
  input  logic [IDX_W-1:0]    last_idx,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  localparam logic [PORT_NUM-1:0] ONE_HOT0 = {{(PORT_NUM-1){1'b0}}, 1'b1};

  // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    int p;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    for (int off = PORT_NUM; off >= 1; off--) begin
      p = int'(last_idx) + off;
      if (p >= PORT_NUM) p = p - PORT_NUM;
      if ((req & (ONE_HOT0 << p)) != '0) begin
        found = 1'b1;
        idx   = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/fifo_sel_arb.sv
// Grant-holding FIFO select arbiter with one-hot grant, bounded hold and a forced gap
// cycle between owners. Define FIFO_SEL_ARB_RR_EN for round-robin, else fixed priority.
module fifo_sel_arb
  import fifo_sel_pkg::*;
#(
  parameter int PORT_NUM   = 4,
  parameter int IDX_W      = 7,
  parameter int MAX_HOLD   = 0,
  parameter int HOLD_CNT_W = 16
) (
  input  logic                glb_clk,
  input  logic                glb_areset,
  input  logic [PORT_NUM-1:0] fifo_sel_bits,
  input  logic                sel_release,
  output logic [7:0]          fifo_sel_res_final,
  output logic [PORT_NUM-1:0] fifo_grant,
  output logic                grant_valid
);

  localparam logic [PORT_NUM-1:0]   ONE_HOT0 = {{(PORT_NUM-1){1'b0}}, 1'b1};
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM =
    (MAX_HOLD == 0) ? '0 : HOLD_CNT_W'(MAX_HOLD - 1);

  sel_state_e              state_q, state_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]              res_q, res_d;
  logic [PORT_NUM-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]        search_base;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic                    owner_req;
  logic                    other_req;
  logic                    forced;

`ifdef FIFO_SEL_ARB_RR_EN
  logic [IDX_W-1:0]        last_idx_q;

  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      last_idx_q <= IDX_W'(PORT_NUM - 1);
    end else if (state_q == GRANT && state_d == GAP) begin
      last_idx_q <= grant_idx_q;
    end
  end

  assign search_base = last_idx_q;
`else
  // Searching upward from PORT_NUM-1 always starts at port 0, i.e. lowest index wins.
  assign search_base = IDX_W'(PORT_NUM - 1);
`endif

  fifo_sel_rr_pick #(
    .PORT_NUM (PORT_NUM),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req      (fifo_sel_bits),
    .last_idx (search_base),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign owner_req = (fifo_sel_bits & (ONE_HOT0 << grant_idx_q)) != '0;
  assign other_req = (fifo_sel_bits & ~(ONE_HOT0 << grant_idx_q)) != '0;
  assign forced    = (MAX_HOLD != 0) && (hold_cnt_q >= HOLD_LIM) && other_req;

  // GAP arbitrates like IDLE, so exactly one unselected cycle separates two owners.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    hold_cnt_d  = hold_cnt_q;
    res_d       = res_q;
    grant_d     = grant_q;
    case (state_q)
      IDLE, GAP: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
        res_d      = NON_FIFO_CHOOSE;
        grant_d    = '0;
        if (pick_found) begin
          state_d     = GRANT;
          grant_idx_d = pick_idx;
          res_d       = sel_code(pick_idx);
          grant_d     = ONE_HOT0 << pick_idx;
        end
      end
      GRANT: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
        if (sel_release || !owner_req || forced) begin
          state_d    = GAP;
          hold_cnt_d = '0;
          res_d      = NON_FIFO_CHOOSE;
          grant_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        res_d   = NON_FIFO_CHOOSE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      hold_cnt_q  <= '0;
      res_q       <= NON_FIFO_CHOOSE;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      res_q       <= res_d;
      grant_q     <= grant_d;
    end
  end

  assign fifo_sel_res_final = res_q;
  assign fifo_grant         = grant_q;
  assign grant_valid        = res_q[SEL_VALID_BIT];

endmodule

// File: tb/tb_fifo_sel_arb.sv
// Scoreboard bench for fifo_sel_arb: a 4-port instance with MAX_HOLD=4 and a
// 16-port instance with no hold limit, driven by directed vectors.
module tb_fifo_sel_arb;

`ifdef FIFO_SEL_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [3:0]  reqA;
  logic        relA;
  logic [15:0] reqB;
  logic        relB;
  logic [7:0]  resA, resB;
  logic [3:0]  grantA;
  logic [15:0] grantB;
  logic        validA, validB;

  exp_t expQ[$];
  int   testsRun;
  int   testsFailed;

  fifo_sel_arb #(.PORT_NUM(4), .IDX_W(7), .MAX_HOLD(4), .HOLD_CNT_W(16)) dutA (
    .glb_clk            (clock),
    .glb_areset         (reset),
    .fifo_sel_bits      (reqA),
    .sel_release        (relA),
    .fifo_sel_res_final (resA),
    .fifo_grant         (grantA),
    .grant_valid        (validA)
  );

  fifo_sel_arb #(.PORT_NUM(16), .IDX_W(7), .MAX_HOLD(0), .HOLD_CNT_W(16)) dutB (
    .glb_clk            (clock),
    .glb_areset         (reset),
    .fifo_sel_bits      (reqB),
    .sel_release        (relB),
    .fifo_sel_res_final (resB),
    .fifo_grant         (grantB),
    .grant_valid        (validB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] res, input logic [15:0] grant,
                             input logic valid, input logic [7:0] expCode);
    logic [15:0] expGrant;
    logic        expValid;
    expValid = expCode[7];
    expGrant = expValid ? (16'd1 << expCode[6:0]) : 16'd0;
    testsRun++;
    if (res !== expCode || grant !== expGrant || valid !== expValid) begin
      testsFailed++;
      $display("[TB] FAIL %s @%0t: got res=%0d grant=%h valid=%b, want res=%0d grant=%h valid=%b",
               name, $time, res, grant, valid, expCode, expGrant, expValid);
    end
  endtask

  // Inputs change at the falling edge; the pushed codes are what must appear after the next rise.
  task automatic applyStimulus(input logic rstv, input logic [3:0] ra, input logic la,
                               input logic [7:0] ea, input logic [15:0] rb, input logic lb,
                               input logic [7:0] eb);
    exp_t e;
    @(negedge clock);
    reset = rstv;
    reqA  = ra;
    relA  = la;
    reqB  = rb;
    relB  = lb;
    e.a   = ea;
    e.b   = eb;
    expQ.push_back(e);
  endtask

  task automatic stepA(input logic [3:0] ra, input logic la, input logic [7:0] ea);
    applyStimulus(1'b0, ra, la, ea, 16'h0000, 1'b0, 8'd0);
  endtask

  task automatic stepB(input logic [15:0] rb, input logic lb, input logic [7:0] eb);
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'd0, rb, lb, eb);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("dutA", resA, {12'd0, grantA}, validA, e.a);
      checkOutput("dutB", resB, grantB, validB, e.b);
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b1;
    reqA  = '0;
    relA  = 1'b0;
    reqB  = '0;
    relB  = 1'b0;

    applyStimulus(1'b1, 4'b1111, 1'b0, 8'd0, 16'hFFFF, 1'b0, 8'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 8'd0, 16'hFFFF, 1'b0, 8'd0);
    stepA(4'b0000, 1'b0, 8'd0);

    // All four ports requesting, owner releases after every grant.
    stepA(4'b1111, 1'b0, 8'd128);
    stepA(4'b1111, 1'b1, 8'd0);
    stepA(4'b1111, 1'b0, RR ? 8'd129 : 8'd128);
    stepA(4'b1111, 1'b1, 8'd0);
    stepA(4'b1111, 1'b0, RR ? 8'd130 : 8'd128);
    stepA(4'b1111, 1'b1, 8'd0);
    stepA(4'b1111, 1'b0, RR ? 8'd131 : 8'd128);
    stepA(4'b1111, 1'b1, 8'd0);
    stepA(4'b1111, 1'b0, 8'd128);
    stepA(4'b1111, 1'b1, 8'd0);
    stepA(4'b0000, 1'b0, 8'd0);

    // Port 3 withdraws; port 1 takes over after the gap and ignores a new request from port 0.
    stepA(4'b1000, 1'b0, 8'd131);
    stepA(4'b0010, 1'b0, 8'd0);
    stepA(4'b0010, 1'b0, 8'd129);
    stepA(4'b0011, 1'b0, 8'd129);
    stepA(4'b0000, 1'b1, 8'd0);
    stepA(4'b0000, 1'b0, 8'd0);

    // Hold limit of 4 cycles with port 2 waiting.
    stepA(4'b0001, 1'b0, 8'd128);
    stepA(4'b0101, 1'b0, 8'd128);
    stepA(4'b0101, 1'b0, 8'd128);
    stepA(4'b0101, 1'b0, 8'd128);
    stepA(4'b0101, 1'b0, 8'd0);
    stepA(4'b0101, 1'b0, RR ? 8'd130 : 8'd128);
    stepA(4'b0000, 1'b1, 8'd0);
    stepA(4'b0000, 1'b0, 8'd0);

    // Lone requester is never forced out; a late competitor forces release at once.
    stepA(4'b0001, 1'b0, 8'd128);
    for (int i = 0; i < 7; i++) stepA(4'b0001, 1'b0, 8'd128);
    stepA(4'b0011, 1'b0, 8'd0);
    stepA(4'b0011, 1'b0, RR ? 8'd129 : 8'd128);
    stepA(4'b0000, 1'b1, 8'd0);
    stepA(4'b0000, 1'b0, 8'd0);

    // Asynchronous reset while port 2 owns the output.
    stepA(4'b0100, 1'b0, 8'd130);
    stepA(4'b0100, 1'b0, 8'd130);
    applyStimulus(1'b1, 4'b0100, 1'b0, 8'd0, 16'h0000, 1'b0, 8'd0);
    #1;
    checkOutput("dutA async reset", resA, {12'd0, grantA}, validA, 8'd0);
    stepA(4'b0001, 1'b0, 8'd128);
    stepA(4'b0000, 1'b1, 8'd0);
    stepA(4'b0000, 1'b0, 8'd0);

    // 16-port instance: top port, wrap to port 0, no hold limit.
    stepB(16'h8000, 1'b0, 8'd143);
    stepB(16'h8000, 1'b1, 8'd0);
    stepB(16'h8001, 1'b0, 8'd128);
    for (int i = 0; i < 6; i++) stepB(16'h8001, 1'b0, 8'd128);
    stepB(16'h8001, 1'b1, 8'd0);
    stepB(16'h8001, 1'b0, RR ? 8'd143 : 8'd128);
    stepB(16'h0000, 1'b1, 8'd0);
    stepB(16'h0000, 1'b0, 8'd0);

    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(posedge clock);
    #2;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d expected entries left, want 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
